instr_fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of riscv_processor; drives its 32-bit instruction input.
- Owns the program counter and issues word reads to a synchronous instruction memory.
- Buffers returned words in a small prefetch FIFO.
- Presents instructions over a valid/ready handshake.
- Accepts PC redirects (branch/jump), which flush all buffered and in-flight fetches.

---
 rtl/instr_fetch_unit.sv | 113 +++++++++++
 tb/tb_instr_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads a 1-cycle sync imem, buffers words in a prefetch FIFO (IF_MISALIGN_CHECK_EN: misaligned-redirect fault).
// Latency: req cycle 0, rvalid cycle 1, instr_valid cycle 2; redirect to first valid output is 3 cycles.
// Backpressure: requests are credit-limited (buffered + in flight < FIFO_DEPTH); instr_ready low stalls fetch.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_fault
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic [31:0]   redirect_target;
  logic          inflight;
  logic          drop;
  logic          fault;
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] credit_used;
  logic          push;
  logic          pop;

`ifdef IF_MISALIGN_CHECK_EN
  assign redirect_target = redirect_pc;

  // Sticky until reset or an aligned redirect; halts request issue while set.
  always_ff @(posedge clk) begin
    if (rst)
      fault <= 1'b0;
    else if (redirect_valid)
      fault <= (redirect_pc[1:0] != 2'b00);
  end
`else
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign fault           = 1'b0;
`endif

  assign fetch_fault = fault;
  assign imem_addr   = fetch_pc;
  assign credit_used = count + CW'(inflight);
  assign imem_req    = !rst && !redirect_valid && !fault && (credit_used < DEPTH_C);

  assign push        = imem_rvalid && !drop;
  assign instr_valid = (count != '0) && !redirect_valid;
  assign pop         = instr_valid && instr_ready;
  assign instruction = instr_valid ? fifo_instr[rd_ptr] : NOP_INSTR;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]    : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      // A response still owed by memory after reset must not reach the FIFO.
      drop        <= inflight && !imem_rvalid;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
      inflight <= inflight && !imem_rvalid;
      drop     <= inflight && !imem_rvalid;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (imem_req) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
      inflight <= imem_req || (inflight && !imem_rvalid);
      if (imem_rvalid)
        drop <= 1'b0;
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid && push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run against a queue-based fetch model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_rvalid = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .fetch_fault(fetch_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h001080B3;
      32'h4:   return 32'h40210133;
      32'h8:   return 32'h003191B3;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  // Synchronous instruction memory: data one cycle after an accepted request.
  always @(posedge clk) begin
    imem_rvalid <= imem_req;
    imem_rdata  <= mem_word(imem_addr);
  end

  // Reference model: queue of PCs requested and not yet consumed; a word is
  // presentable two cycles after its request, requests limited by queue size.
  logic [31:0] q_pc[$];
  int          q_cyc[$];
  logic [31:0] m_pc = '0;
  logic        m_fault = 1'b0;
  int          cyc = 0;

  function automatic logic m_valid();
    if (q_pc.size() == 0 || redirect_valid) return 1'b0;
    return (q_cyc[0] + 2 <= cyc);
  endfunction

  function automatic logic m_req();
    return !rst && !redirect_valid && !m_fault && (q_pc.size() < FIFO_DEPTH);
  endfunction

  always @(posedge clk) begin : model
    bit v, rq;
    v  = m_valid();
    rq = m_req();
    if (rst) begin
      q_pc.delete(); q_cyc.delete();
      m_pc = RESET_PC; m_fault = 1'b0;
    end else if (redirect_valid) begin
      q_pc.delete(); q_cyc.delete();
`ifdef IF_MISALIGN_CHECK_EN
      m_pc = redirect_pc; m_fault = (redirect_pc[1:0] != 2'b00);
`else
      m_pc = {redirect_pc[31:2], 2'b00};
`endif
    end else begin
      if (v && instr_ready) begin
        void'(q_pc.pop_front()); void'(q_cyc.pop_front());
      end
      if (rq) begin
        q_pc.push_back(m_pc); q_cyc.push_back(cyc);
        m_pc = m_pc + 32'd4;
      end
    end
    cyc = cyc + 1;
  end

  task automatic drive(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_pc = rp; instr_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0); drive(1, 0, 0, 0); drive(1, 0, 0, 0);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", instr_valid); end
    total++; if (instruction !== NOP) begin bad++; $display("FAIL reset_instr got=%h want=%h", instruction, NOP); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", instr_pc); end
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b want=0", fetch_fault); end
    total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL reset_addr got=%h want=%h", imem_addr, RESET_PC); end
  endtask

  task automatic test_basic();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h001080B3; exp_w[1] = 32'h40210133; exp_w[2] = 32'h003191B3;
    drive(0, 0, 0, 1);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL basic_first_req got=%b/%h want=1/0", imem_req, imem_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL basic_c0_valid got=%b want=0", instr_valid); end
    drive(0, 0, 0, 1);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL basic_c1_valid got=%b want=0", instr_valid); end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1);
      total++; if (instr_valid !== 1'b1 || instruction !== exp_w[k] || instr_pc !== 32'(4 * k)) begin
        bad++; $display("FAIL basic_seq%0d got=%b/%h/%h want=1/%h/%h", k, instr_valid, instruction, instr_pc, exp_w[k], 4 * k);
      end
    end
  endtask

  task automatic test_backpressure();
    int nreq = 0;
    drive(1, 0, 0, 0); drive(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0);
      if (imem_req === 1'b1) begin
        total++; if (imem_addr !== 32'(4 * nreq)) begin
          bad++; $display("FAIL bp_addr%0d got=%h want=%h", nreq, imem_addr, 4 * nreq); end
        nreq++;
      end
    end
    total++; if (nreq != 4) begin bad++; $display("FAIL bp_nreq got=%0d want=4", nreq); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_req_stalled got=%b want=0", imem_req); end
    for (int k = 0; k < 12; k++) begin
      drive(0, 0, 0, 1);
      if (k == 0) begin
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_req_before_free got=%b want=0", imem_req); end
      end
      if (k == 1) begin
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'd16) begin
          bad++; $display("FAIL bp_resume got=%b/%h want=1/10", imem_req, imem_addr); end
      end
      total++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k) || instruction !== mem_word(32'(4 * k))) begin
        bad++; $display("FAIL bp_drain%0d got=%b/%h/%h want=1/%h/%h", k, instr_valid, instr_pc, instruction, 4 * k, mem_word(32'(4 * k)));
      end
    end
  endtask

  task automatic test_redirect();
    drive(1, 0, 0, 0); drive(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'd12) begin
      bad++; $display("FAIL redir_pre_inflight got=%b/%h want=1/c", imem_req, imem_addr); end
    drive(0, 1, 32'h100, 1);
    total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL redir_R got=%b/%b want=0/0", imem_req, instr_valid); end
    drive(0, 0, 0, 1);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL redir_R1 got=%b/%h/%b want=1/100/0", imem_req, imem_addr, instr_valid); end
    drive(0, 0, 0, 1);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_R2 got=%b want=0", instr_valid); end
    drive(0, 0, 0, 1);
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instruction !== mem_word(32'h100)) begin
      bad++; $display("FAIL redir_R3 got=%b/%h/%h want=1/100/%h", instr_valid, instr_pc, instruction, mem_word(32'h100)); end
    drive(0, 0, 0, 1);
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h104) begin
      bad++; $display("FAIL redir_R4 got=%b/%h want=1/104", instr_valid, instr_pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_p [3];
    int got = 0;
    exp_p[0] = 32'hFFFF_FFF8; exp_p[1] = 32'hFFFF_FFFC; exp_p[2] = 32'h0000_0000;
    drive(0, 1, 32'hFFFF_FFF8, 1);
    for (int i = 0; i < 12 && got < 3; i++) begin
      drive(0, 0, 0, 1);
      if (instr_valid === 1'b1) begin
        total++; if (instr_pc !== exp_p[got] || instruction !== mem_word(exp_p[got])) begin
          bad++; $display("FAIL wrap%0d got=%h/%h want=%h/%h", got, instr_pc, instruction, exp_p[got], mem_word(exp_p[got])); end
        got++;
      end
    end
    total++; if (got != 3) begin bad++; $display("FAIL wrap_timeout got=%0d want=3", got); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 1);
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rmid_outstanding got=%b want=1", imem_req); end
    drive(1, 0, 0, 1);
    drive(0, 0, 0, 1);
    total++; if (instr_valid !== 1'b0 || instruction !== NOP || instr_pc !== 32'h0 || fetch_fault !== 1'b0) begin
      bad++; $display("FAIL rmid_outputs got=%b/%h/%h/%b want=0/%h/0/0", instr_valid, instruction, instr_pc, fetch_fault, NOP); end
    total++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      bad++; $display("FAIL rmid_restart got=%b/%h want=1/%h", imem_req, imem_addr, RESET_PC); end
    drive(0, 0, 0, 1);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale got=%b/%h want=0", instr_valid, instr_pc); end
    drive(0, 0, 0, 1);
    total++; if (instr_valid !== 1'b1 || instr_pc !== RESET_PC || instruction !== mem_word(RESET_PC)) begin
      bad++; $display("FAIL rmid_first got=%b/%h/%h want=1/%h/%h", instr_valid, instr_pc, instruction, RESET_PC, mem_word(RESET_PC)); end
  endtask

  task automatic test_misalign();
`ifdef IF_MISALIGN_CHECK_EN
    int nreq = 0, nfault = 0, nvalid = 0;
    drive(0, 1, 32'h102, 1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 1);
      if (imem_req !== 1'b0) nreq++;
      if (fetch_fault === 1'b1) nfault++;
      if (instr_valid !== 1'b0) nvalid++;
    end
    total++; if (nreq != 0) begin bad++; $display("FAIL mis_req got=%0d want=0", nreq); end
    total++; if (nfault != 10) begin bad++; $display("FAIL mis_fault got=%0d want=10", nfault); end
    total++; if (nvalid != 0) begin bad++; $display("FAIL mis_valid got=%0d want=0", nvalid); end
    drive(0, 1, 32'h200, 1);
    drive(0, 0, 0, 1);
    total++; if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      bad++; $display("FAIL mis_clear got=%b/%b/%h want=0/1/200", fetch_fault, imem_req, imem_addr); end
    drive(0, 0, 0, 1); drive(0, 0, 0, 1);
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin
      bad++; $display("FAIL mis_resume got=%b/%h want=1/200", instr_valid, instr_pc); end
`else
    drive(0, 1, 32'h102, 1);
    drive(0, 0, 0, 1);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || fetch_fault !== 1'b0) begin
      bad++; $display("FAIL mis_align got=%b/%h/%b want=1/100/0", imem_req, imem_addr, fetch_fault); end
    drive(0, 0, 0, 1); drive(0, 0, 0, 1);
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instruction !== mem_word(32'h100)) begin
      bad++; $display("FAIL mis_deliver got=%b/%h/%h want=1/100/%h", instr_valid, instr_pc, instruction, mem_word(32'h100)); end
`endif
  endtask

  task automatic test_random();
    logic        r, rv, rdy;
    logic [31:0] rp;
    int          errs = 0;
    drive(1, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(99) < 2);
      rv  = !r && ($urandom_range(99) < 4);
      rp  = $urandom();
      if ($urandom_range(3) != 0) rp[1:0] = 2'b00;
      if ($urandom_range(3) == 0) rp[31:8] = 24'hFFFFFF;
      rdy = ($urandom_range(99) < 70);
      drive(r, rv, rp, rdy);
      total++; if (imem_req !== m_req() || imem_addr !== m_pc || fetch_fault !== m_fault) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rnd_req c=%0d got=%b/%h/%b want=%b/%h/%b", cyc, imem_req, imem_addr, fetch_fault, m_req(), m_pc, m_fault);
      end
      total++;
      if (m_valid()) begin
        if (instr_valid !== 1'b1 || instr_pc !== q_pc[0] || instruction !== mem_word(q_pc[0])) begin
          bad++; errs++;
          if (errs < 10) $display("FAIL rnd_out c=%0d got=%b/%h/%h want=1/%h/%h", cyc, instr_valid, instr_pc, instruction, q_pc[0], mem_word(q_pc[0]));
        end
      end else if (instr_valid !== 1'b0 || instruction !== NOP) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rnd_idle c=%0d got=%b/%h want=0/%h", cyc, instr_valid, instruction, NOP);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_misalign();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
